// File: rtl/sram_responder_pkg.sv
// sram_responder_pkg: FSM encoding and sizing helpers shared by
// the tester-side asynchronous SRAM responder and its bus interface.
package sram_responder_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD      = 2'd1;
    localparam logic [1:0] ST_WR      = 2'd2;
    localparam logic [1:0] ST_WR_HOLD = 2'd3;

    function automatic int cnt_width(input int rd_wait, input int wr_wait);
        int m;
        m = (rd_wait > wr_wait) ? rd_wait : wr_wait;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    function automatic bit data_width_ok(input int dw);
        return dw == 16;
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// sram_responder_if: tester memory bus (address/read/write with
// waitrequest back-pressure and a readdataready pulse).
interface sram_responder_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] address;
    logic [BE_WIDTH-1:0]   byteenable;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  waitrequest;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdataready;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdataready
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdataready
    );

endinterface

// File: rtl/sram_responder.sv
// sram_responder: one-transaction-at-a-time bridge from the tester
// memory bus to a 16-bit asynchronous SRAM with fixed wait states.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    sram_responder_if.slave       bus,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_dq_in,
    output logic [DATA_WIDTH-1:0] sram_dq_out,
    output logic                  sram_dq_oe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  sram_ub_n,
    output logic                  sram_lb_n
);

    localparam int CW = cnt_width(READ_WAIT, WRITE_WAIT);

    if (!data_width_ok(DATA_WIDTH)) begin : g_bad_dw
        $error("sram_responder: DATA_WIDTH must be 16");
    end
    if (READ_WAIT < 1 || WRITE_WAIT < 1) begin : g_bad_wait
        $error("sram_responder: wait counts must be >= 1");
    end

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;
    logic [BE_WIDTH-1:0] be_q;
    logic [BE_WIDTH-1:0] be_nxt;
    logic                accept;
    logic                wr_acc;
    logic                rd_acc;
    logic                rd_done;
    logic                wr_phase;

    assign bus.waitrequest = reset | (state != ST_IDLE);

    assign accept  = (state == ST_IDLE) & (bus.read | bus.write);
    assign wr_acc  = accept & bus.write;
    assign rd_acc  = accept & ~bus.write;
    assign rd_done = (state == ST_RD) & (cnt == CW'(1));
    assign be_nxt  = accept ? bus.byteenable : be_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (1'b1)
            state == ST_IDLE: begin
                if (wr_acc) begin
                    state_nxt = ST_WR;
                    cnt_nxt   = CW'(WRITE_WAIT);
                end else if (rd_acc) begin
                    state_nxt = ST_RD;
                    cnt_nxt   = CW'(READ_WAIT);
                end
            end
            state == ST_RD: begin
                if (cnt == CW'(1)) state_nxt = ST_IDLE;
                else               cnt_nxt   = cnt - CW'(1);
            end
            state == ST_WR: begin
                if (cnt == CW'(1)) state_nxt = ST_WR_HOLD;
                else               cnt_nxt   = cnt - CW'(1);
            end
            state == ST_WR_HOLD: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so pins change on the
    // same edge as the FSM and never glitch.
    assign wr_phase = (state_nxt == ST_WR) | (state_nxt == ST_WR_HOLD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            be_q              <= '0;
            bus.readdata      <= '0;
            bus.readdataready <= 1'b0;
            sram_addr         <= '0;
            sram_dq_out       <= '0;
            sram_dq_oe        <= 1'b0;
            sram_ce_n         <= 1'b1;
            sram_oe_n         <= 1'b1;
            sram_we_n         <= 1'b1;
            sram_ub_n         <= 1'b1;
            sram_lb_n         <= 1'b1;
        end else begin
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            be_q              <= be_nxt;
            bus.readdataready <= rd_done;
            if (rd_done) bus.readdata <= sram_dq_in;
            if (accept) begin
                sram_addr   <= bus.address;
                sram_dq_out <= bus.writedata;
            end
            sram_ce_n  <= (state_nxt == ST_IDLE);
            sram_oe_n  <= (state_nxt != ST_RD);
            sram_we_n  <= (state_nxt != ST_WR);
            sram_dq_oe <= wr_phase;
            sram_ub_n  <= (state_nxt == ST_RD) ? 1'b0 :
                          wr_phase ? ~be_nxt[1] : 1'b1;
            sram_lb_n  <= (state_nxt == ST_RD) ? 1'b0 :
                          wr_phase ? ~be_nxt[0] : 1'b1;
        end
    end

endmodule
